// File: rtl/case_1_sdiv_pkg.sv
// Shared types and widths for the sequential signed divider.
// State encoding plus the counter-width helper.
package case_1_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam int DIN0_W = 8;
    localparam int DIN1_W = 4;
    localparam int DOUT_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/case_1_sdiv_8s_4s_8_seq_if.sv
// Operand/result handshake bundle for the signed divider.
// The divider is the slave; the producer/consumer side is the master.
interface case_1_sdiv_8s_4s_8_seq_if
    import case_1_sdiv_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] quot;
    logic [din1_WIDTH-1:0] rem;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem,
        input  div_by_zero, overflow
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem,
        output div_by_zero, overflow
    );

endinterface

// File: rtl/case_1_sdiv_8s_4s_8_seq_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, restore on borrow.
module case_1_sdiv_step #(
    parameter int W = 4
) (
    input  logic [W:0]   i_pr,
    input  logic         i_bit,
    input  logic [W-1:0] i_dsr,
    output logic [W:0]   o_pr,
    output logic         o_q
);

    logic [W:0]   w_sh;
    logic [W+1:0] w_diff;

    assign w_sh   = {i_pr[W-1:0], i_bit};
    assign w_diff = {1'b0, w_sh} - {2'b00, i_dsr};
    assign o_q    = ~w_diff[W+1];
    assign o_pr   = o_q ? w_diff[W:0] : w_sh;

endmodule

// File: rtl/case_1_sdiv_8s_4s_8_seq.sv
// Multi-cycle signed divider, C semantics (truncate toward zero),
// restoring algorithm on magnitudes with sign fix-up at the end.
module case_1_sdiv_8s_4s_8_seq
    import case_1_sdiv_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    case_1_sdiv_8s_4s_8_seq_if.slave bus
);

    localparam int N  = din0_WIDTH;
    localparam int W  = din1_WIDTH;
    localparam int CW = clog2(N);

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]         r_cnt;
    logic [N-1:0]          r_dvd;
    logic [W-1:0]          r_dsr;
    logic [W:0]            r_pr;
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic                  r_dbz;
    logic                  r_ovf_in;
    logic [W-1:0]          r_din0_lo;
    logic [dout_WIDTH-1:0] r_quot;
    logic [W-1:0]          r_rem;
    logic                  r_dbz_o;
    logic                  r_ovf_o;

    logic [N-1:0] w_abs0;
    logic [W-1:0] w_abs1;
    logic [W:0]   w_pr;
    logic         w_qbit;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_ovf;

    assign w_abs0 = bus.din0[N-1] ? -bus.din0 : bus.din0;
    assign w_abs1 = bus.din1[W-1] ? -bus.din1 : bus.din1;
    assign w_ovf  = (bus.din0 == {1'b1, {(N-1){1'b0}}})
                  && (bus.din1 == {W{1'b1}});

    // Quotient bits are shifted into the vacated LSBs of r_dvd.
    case_1_sdiv_step #(
        .W(W)
    ) u_step (
        .i_pr  (r_pr),
        .i_bit (r_dvd[N-1]),
        .i_dsr (r_dsr),
        .o_pr  (w_pr),
        .o_q   (w_qbit)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = RUN;
            end
            RUN: begin
                if (r_cnt == '0) w_next = FIX;
            end
            FIX: begin
                w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_pr      <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf_in  <= 1'b0;
            r_din0_lo <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz_o   <= 1'b0;
            r_ovf_o   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_dvd     <= w_abs0;
                        r_dsr     <= w_abs1;
                        r_pr      <= '0;
                        r_sign_q  <= bus.din0[N-1] ^ bus.din1[W-1];
                        r_sign_r  <= bus.din0[N-1];
                        r_dbz     <= (bus.din1 == '0);
                        r_ovf_in  <= w_ovf;
                        r_din0_lo <= bus.din0[W-1:0];
                        r_cnt     <= CW'(N - 1);
                    end
                end
                RUN: begin
                    r_pr  <= w_pr;
                    r_dvd <= {r_dvd[N-2:0], w_qbit};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    if (r_dbz) begin
                        r_quot  <= '1;
                        r_rem   <= r_din0_lo;
                        r_dbz_o <= 1'b1;
                        r_ovf_o <= 1'b0;
                    end else begin
                        r_quot  <= r_sign_q ? dout_WIDTH'(-r_dvd)
                                            : dout_WIDTH'(r_dvd);
                        r_rem   <= r_sign_r ? -r_pr[W-1:0]
                                            : r_pr[W-1:0];
                        r_dbz_o <= 1'b0;
                        r_ovf_o <= r_ovf_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.quot        = r_quot;
    assign bus.rem         = r_rem;
    assign bus.div_by_zero = r_dbz_o;
    assign bus.overflow    = r_ovf_o;

endmodule

// File: tb/tb_case_1_sdiv_8s_4s_8_seq.sv
// Directed bench for the sequential signed divider.
// Expected quotients/remainders are hand-computed C-style results.
module tb_case_1_sdiv_8s_4s_8_seq;

    logic ap_clk;
    logic ap_rst_n;
    int   total;
    int   bad;

    case_1_sdiv_8s_4s_8_seq_if bus ();

    case_1_sdiv_8s_4s_8_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic accept(input string tag,
                          input logic [7:0] a,
                          input logic [3:0] b);
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.din0     = 8'h00;
        bus.din1     = 4'h0;
    endtask

    // Accept edge closes cycle T; out_valid is first high in T+10,
    // i.e. visible after the 9th further edge.
    task automatic run_op(input string tag,
                          input logic [7:0] a,
                          input logic [3:0] b,
                          input logic [7:0] eq,
                          input logic [3:0] er,
                          input logic edbz,
                          input logic eovf,
                          input bit rel);
        int n;
        accept(tag, a, b);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd9);
        check({tag, "_q"}, 32'(bus.quot), 32'(eq));
        check({tag, "_r"}, 32'(bus.rem), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eovf));
        if (rel) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        int seen;
        total         = 0;
        bad           = 0;
        ap_rst_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din0      = 8'h00;
        bus.din1      = 4'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.quot), 32'd0);
        check("rst_r", 32'(bus.rem), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        ap_rst_n = 1'b1;
        tick();

        run_op("p_p", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b1);
        run_op("n_p", 8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 1'b0, 1'b1);
        run_op("p_n", 8'h64, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0, 1'b1);
        run_op("n_n", 8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0, 1'b0, 1'b1);
        run_op("ovf", 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 1'b1);
        run_op("min1", 8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0, 1'b1);
        run_op("dbz", 8'h05, 4'h0, 8'hFF, 4'h5, 1'b1, 1'b0, 1'b1);
        run_op("d1", 8'h05, 4'h1, 8'h05, 4'h0, 1'b0, 1'b0, 1'b1);

        // Hold the result under backpressure; stray operands must be ignored.
        run_op("bp", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.din0     = 8'h11;
        bus.din1     = 4'h3;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_ov", 32'(bus.out_valid), 32'd1);
            check("bp_q", 32'(bus.quot), 32'h0E);
            check("bp_r", 32'(bus.rem), 32'h2);
            check("bp_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_drop", 32'(bus.out_valid), 32'd0);
        check("bp_rdy1", 32'(bus.in_ready), 32'd1);
        run_op("m8", 8'h64, 4'h8, 8'hF4, 4'h4, 1'b0, 1'b0, 1'b1);

        // Reset mid-iteration: cnt is 3 four edges after the accept.
        accept("rr", 8'h64, 4'h7);
        for (int i = 0; i < 4; i++) tick();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("rr_rdy", 32'(bus.in_ready), 32'd1);
        check("rr_ov", 32'(bus.out_valid), 32'd0);
        check("rr_q", 32'(bus.quot), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("rr_nopart", 32'(seen), 32'd0);
        run_op("rr2", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
